// File: rtl/rtc_bk_sequencer_pkg.sv
// gb_rtc_bk_pkg: shared types and word layout for the RTC backup sequencer.
// RTC_BK_CHECKSUM_EN adds a fifth XOR checksum word to each transfer.
package gb_rtc_bk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_SEND,
        ST_LOAD_RECV,
        ST_LOAD_COMMIT,
        ST_FINISH
    } state_t;

`ifdef RTC_BK_CHECKSUM_EN
    localparam int RTC_BK_WORDS = 5;
`else
    localparam int RTC_BK_WORDS = 4;
`endif

    localparam logic [2:0] RTC_BK_COMMIT_IDX = 3'd4;
    localparam logic [2:0] IDX_TS_LO = 3'd0;
    localparam logic [2:0] IDX_TS_HI = 3'd1;
    localparam logic [2:0] IDX_ST_LO = 3'd2;
    localparam logic [2:0] IDX_ST_HI = 3'd3;
    localparam logic [2:0] IDX_CSUM  = 3'd4;

    // Snapshot is packed {savedtime, timestamp} so words 0..3 are consecutive 16-bit slices.
    function automatic logic [15:0] rtc_bk_word(input logic [63:0] snap, input logic [2:0] idx);
        return (idx == IDX_CSUM) ? snap[15:0] ^ snap[31:16] ^ snap[47:32] ^ snap[63:48]
                                 : snap[{idx[1:0], 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/rtc_bk_sequencer_watchdog.sv
// rtc_bk_watchdog: stall counter; expire pulses on the cycle whose edge brings the count to TIMEOUT_CYCLES-1.
module rtc_bk_watchdog #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= (en && !clr) ? r_cnt + 1'b1 : '0;
    end

    assign expire = en && !clr && (r_cnt == W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/rtc_bk_sequencer.sv
// rtc_bk_sequencer: moves MBC3 RTC state between the mapper bk_rtc_* port and the HPS save stream.
// Define RTC_BK_CHECKSUM_EN to append/verify an XOR checksum word; otherwise 4 words each way.
module rtc_bk_sequencer
    import gb_rtc_bk_pkg::*;
#(
    parameter logic [16:0] BK_BASE        = 17'd0,
    parameter int          TIMEOUT_CYCLES = 65536
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        save_req,
    input  logic        load_req,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        RTC_inuse,
    input  logic [31:0] RTC_timestampOut,
    input  logic [31:0] RTC_savedtimeOut,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        bk_rtc_wr,
    output logic [16:0] bk_addr,
    output logic [15:0] bk_data
);
    localparam logic [2:0] LAST_IDX = 3'(RTC_BK_WORDS - 1);

    state_t      r_state, w_next;
    logic [63:0] r_snap;
    logic [2:0]  r_idx;
    logic        r_err;
    logic        r_bk_wr;
    logic [16:0] r_bk_addr;
    logic [15:0] r_bk_data;
    logic        w_save_hs, w_load_hs, w_hs, w_last, w_expire, w_csum_ok, w_wd_en, w_req;

    assign w_save_hs = (r_state == ST_SAVE_SEND) && dout_ready;
    assign w_load_hs = (r_state == ST_LOAD_RECV) && din_valid;
    assign w_hs      = w_save_hs || w_load_hs;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_wd_en   = (r_state == ST_SAVE_SEND) || (r_state == ST_LOAD_RECV);
    assign w_req     = (r_state == ST_IDLE) && (save_req || load_req);

`ifdef RTC_BK_CHECKSUM_EN
    logic [15:0] r_xor;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                  r_xor <= '0;
        else if (r_state == ST_IDLE)   r_xor <= '0;
        else if (w_load_hs)            r_xor <= r_xor ^ din;
    end
    assign w_csum_ok = (r_idx != IDX_CSUM) || (din == r_xor);
`else
    assign w_csum_ok = 1'b1;
`endif

    rtc_bk_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .en      (w_wd_en),
        .clr     (w_hs),
        .expire  (w_expire)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:        w_next = load_req ? ST_LOAD_RECV
                                   : save_req ? (RTC_inuse ? ST_SAVE_SEND : ST_FINISH) : ST_IDLE;
            ST_SAVE_SEND:   w_next = ((w_save_hs && w_last) || w_expire) ? ST_FINISH : ST_SAVE_SEND;
            ST_LOAD_RECV:   w_next = (w_load_hs && w_last) ? (w_csum_ok ? ST_LOAD_COMMIT : ST_FINISH)
                                   : w_expire ? ST_FINISH : ST_LOAD_RECV;
            ST_LOAD_COMMIT: w_next = ST_FINISH;
            default:        w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_bk_wr   <= 1'b0;
            r_bk_addr <= '0;
            r_bk_data <= '0;
        end else begin
            r_state <= w_next;
            r_bk_wr <= 1'b0;
            if (r_state == ST_IDLE) r_idx <= '0;
            else if (w_hs)          r_idx <= r_idx + 3'd1;
            if (w_req) r_err <= 1'b0;
            else if (w_expire || (w_load_hs && w_last && !w_csum_ok)) r_err <= 1'b1;
            if ((r_state == ST_IDLE) && save_req && !load_req)
                r_snap <= {RTC_savedtimeOut, RTC_timestampOut};
            // The checksum word is only compared, never written to the mapper.
            if (w_load_hs && (r_idx != IDX_CSUM)) begin
                r_bk_wr   <= 1'b1;
                r_bk_addr <= BK_BASE + 17'(r_idx);
                r_bk_data <= din;
            end else if (r_state == ST_LOAD_COMMIT) begin
                r_bk_wr   <= 1'b1;
                r_bk_addr <= BK_BASE + 17'(RTC_BK_COMMIT_IDX);
                r_bk_data <= '0;
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FINISH);
    assign err        = r_err;
    assign dout       = rtc_bk_word(r_snap, r_idx);
    assign dout_valid = (r_state == ST_SAVE_SEND);
    assign din_ready  = (r_state == ST_LOAD_RECV);
    assign bk_rtc_wr  = r_bk_wr;
    assign bk_addr    = r_bk_addr;
    assign bk_data    = r_bk_data;

endmodule

// File: doc/rtc_bk_sequencer.md
Name: rtc_bk_sequencer

Overview:
- Sequences transfer of MBC3 RTC state between the cartridge mapper and the HPS save file.
- Save: snapshots RTC_timestampOut/RTC_savedtimeOut and streams them to HPS as 16-bit words.
- Load: accepts words from HPS, drives bk_rtc_wr/bk_addr/bk_data word writes 0..3 into the mapper, then the commit write (addr 4).
- Sits between the HPS save-file engine and the active mapper's bk_rtc_* inputs. Includes a stall watchdog.

Parameters:
- BK_BASE, 17'd0, base added to every bk_addr issued (word index + BK_BASE).
- TIMEOUT_CYCLES, 65536, max cycles without a stream handshake before abort; legal range ≥ 2.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- save_req  in  1  one-cycle pulse: start save
- load_req  in  1  one-cycle pulse: start load
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of any operation
- err  out  1  valid with done: 1 = timeout or checksum fail
- RTC_inuse  in  1  mapper RTC-in-use flag
- RTC_timestampOut  in  32  mapper timestamp
- RTC_savedtimeOut  in  32  mapper packed RTC registers
- dout  out  16  save stream data
- dout_valid  out  1  save stream valid
- dout_ready  in  1  save stream ready
- din  in  16  load stream data
- din_valid  in  1  load stream valid
- din_ready  out  1  load stream ready
- bk_rtc_wr  out  1  one-cycle write strobe to mapper
- bk_addr  out  17  mapper word address
- bk_data  out  16  mapper write data

Behaviour:
- Reset: all outputs 0, FSM in IDLE, snapshot, index and watchdog cleared. Reset mid-operation aborts silently: no done, no commit.
- States: IDLE, SAVE_SEND, LOAD_RECV, LOAD_COMMIT, FINISH.
- Word order, index 0..3: ts[15:0], ts[31:16], st[15:0], st[31:16] (ts = timestamp, st = savedtime).
- IDLE request arbitration:
  - load_req and save_req together: load wins, save dropped.
  - Requests outside IDLE are ignored.
- Save, request at edge n:
  - If RTC_inuse = 0: go to FINISH. done = 1, err = 0 in cycle n+1; no words sent.
  - Otherwise: both 32-bit inputs are captured at edge n into a 64-bit snapshot. dout_valid = 1 from cycle n+1.
  - Index advances on each dout_valid & dout_ready. dout is held stable while valid & !ready.
  - After the last word handshakes: FINISH, done next cycle.
- Load:
  - din_ready = 1 throughout LOAD_RECV.
  - Word k accepted at edge m → bk_rtc_wr = 1 in cycle m+1 with bk_addr = BK_BASE+k, bk_data = word k.
  - Back-to-back accepts yield back-to-back strobes.
  - After word 3: LOAD_COMMIT issues bk_rtc_wr with bk_addr = BK_BASE+4, bk_data = 0 for one cycle, then FINISH.
- FINISH: done = 1 for one cycle, then IDLE. err holds its value until the next request.
- Watchdog:
  - Counts in SAVE_SEND/LOAD_RECV; cleared on every handshake and on state entry.
  - Abort fires when the count reaches TIMEOUT_CYCLES-1 → FINISH with err = 1.
  - On load abort, no commit write is issued; mapper intermediate registers stay uncommitted.
- bk_addr/bk_data hold their last values when bk_rtc_wr = 0.
- Index counter is 3 bits; no wrap is possible because the terminal index is checked explicitly.

Optional Feature:
- Macro: RTC_BK_CHECKSUM_EN.
- When defined:
  - A 5th word (index 4) is appended: XOR of words 0..3.
  - Save sends 5 words.
  - Load receives 5 words. Word 4 is compared, not written; commit is issued only on match. Mismatch → FINISH with err = 1, no commit.
- When undefined: 4 words in each direction; err is set only by timeout.

Decomposition:
- Package gb_rtc_bk_pkg: state enum, RTC_BK_WORDS (4 or 5 per macro), RTC_BK_COMMIT_IDX = 4, word-order index constants.
- Sub-module rtc_bk_watchdog: counter with clear/enable/expire, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Save, ts = 32'h12345678, st = 32'h0ABCDEF0, ready always 1 → dout 5678, 1234, DEF0, 0ABC on consecutive cycles; done 1 cycle after the last word; err = 0.
- Save with dout_ready toggling 1/0, and the inputs changed mid-stream → words still match the snapshot taken at the request; dout stable while stalled.
- Load words 1111, 2222, 3333, 4444 with valid gaps → bk_rtc_wr at addr 0..3 carrying those data, then addr 4 commit; done; err = 0.
- Load stalls after 2 words with TIMEOUT_CYCLES = 16 → done + err = 1 at cycle 15 of the stall; no addr 4 write.
- save_req & load_req in the same cycle, and save_req while busy → load runs; save ignored; save with RTC_inuse = 0 → immediate done, no dout_valid.
- With RTC_BK_CHECKSUM_EN: load with correct XOR word → commit issued; corrupted XOR → err = 1, no commit. reset_n low mid-load → outputs 0 immediately, no done.
